// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Purpose: Shared constants for the instruction-fetch slice: default widths
//          and depth, the delivery counter width, and the NOP encoding that
//          is presented to decode whenever the queue is empty.
// Ports  : (package - none)
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_QDEPTH  = 4;
  localparam int CNT_W       = 16;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetch_if
// Purpose: Bundles the program-counter request channel, the instruction
//          memory port and the decode delivery channel of the fetch unit.
// Ports  : slave  - fetch unit side (consumes pc/mem_rdata/instr_ready)
//          master - environment side (program counter, memory, decode)
// Rev    : 1.0  initial release
// ============================================================================
interface instruction_fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic [ADDR_W-1:0]  pc;
  logic               pc_valid;
  logic               fetch_ready;
  logic               flush;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [CNT_W-1:0]   fetch_count;

  modport slave (
    input  pc, pc_valid, flush, mem_rdata, instr_ready,
    output fetch_ready, mem_addr, instr, instr_pc, instr_valid, fetch_count
  );

  modport master (
    output pc, pc_valid, flush, mem_rdata, instr_ready,
    input  fetch_ready, mem_addr, instr, instr_pc, instr_valid, fetch_count
  );

endinterface : instruction_fetch_if
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module : instr_queue
// Purpose: Synchronous FIFO holding fetched {pc, instruction} entries.
//          Flush empties the queue and overrides any push or pop that cycle.
// Ports  : clock, reset (sync, active-low)
//          i_push/i_data  - write an entry
//          i_pop          - remove the head entry (ignored when empty)
//          i_flush        - discard all entries
//          o_head         - raw head entry (meaningful only when o_count!=0)
//          o_count        - number of stored entries
// Rev    : 1.0  initial release
// ============================================================================
module instr_queue
  import fetch_pkg::*;
#(
  parameter int DATA_W = DEF_ADDR_W + DEF_INSTR_W,
  parameter int DEPTH  = DEF_QDEPTH
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     i_push,
  input  wire logic [DATA_W-1:0]        i_data,
  input  wire logic                     i_pop,
  input  wire logic                     i_flush,
  output logic      [DATA_W-1:0]        o_head,
  output logic      [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_push_en;
  logic w_pop_en;

  // Flush has priority; the full/empty guards keep the pointers coherent
  // even if a caller misbehaves.
  assign w_push_en = i_push & ~i_flush & (r_count != FULL_COUNT);
  assign w_pop_en  = i_pop  & ~i_flush & (r_count != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
      if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clock) begin
    if (w_push_en) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule : instr_queue
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetch
// Purpose: Accepts fetch requests from the program counter, reads an external
//          single-cycle-latency instruction memory, and queues the returned
//          instructions (with their pc) for decode. Supports branch flush.
// Ports  : clock    - single clock, rising edge
//          reset    - synchronous, active-low
//          io_fetch - instruction_fetch_if.slave: pc/pc_valid/fetch_ready,
//                     flush, mem_addr/mem_rdata, instr/instr_pc/instr_valid/
//                     instr_ready, fetch_count
// Rev    : 1.0  initial release
// ============================================================================
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int QDEPTH  = DEF_QDEPTH
) (
  input  wire logic           clock,
  input  wire logic           reset,
  instruction_fetch_if.slave  io_fetch
);

  localparam int QC_W = $clog2(QDEPTH) + 1;
  localparam logic [QC_W:0] DEPTH_LIMIT = (QC_W + 1)'(QDEPTH);

  // One-deep in-flight tag: the request whose data returns this cycle.
  logic               r_tag_valid;
  logic [ADDR_W-1:0]  r_tag_pc;
  logic [CNT_W-1:0]   r_fetch_count;

  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_room;
  logic                      w_q_nonempty;
  logic [QC_W-1:0]           w_q_count;
  logic [QC_W:0]             w_occupancy;
  logic [ADDR_W+INSTR_W-1:0] w_head;

  // Occupancy counts the in-flight slot so a returning fetch always has a
  // free entry; this keeps instr_ready out of the fetch_ready path.
  assign w_occupancy = {1'b0, w_q_count} + {{QC_W{1'b0}}, r_tag_valid};
  assign w_room      = (w_occupancy < DEPTH_LIMIT);

  // A flush discards both the queue and the in-flight slot, so the redirect
  // target can always be accepted.
  assign io_fetch.fetch_ready = reset & (io_fetch.flush | w_room);
  assign w_accept             = io_fetch.pc_valid & io_fetch.fetch_ready;

  assign io_fetch.mem_addr = io_fetch.pc;

  assign w_q_nonempty = (w_q_count != '0);
  assign w_pop        = w_q_nonempty & io_fetch.instr_ready;
  assign w_push       = r_tag_valid & ~io_fetch.flush;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tag_valid   <= 1'b0;
      r_tag_pc      <= '0;
      r_fetch_count <= '0;
    end else begin
      r_tag_valid <= w_accept;
      if (w_accept) r_tag_pc <= io_fetch.pc;
      // A pop coinciding with flush still counts as delivered.
      if (w_pop) r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  instr_queue #(
    .DATA_W (ADDR_W + INSTR_W),
    .DEPTH  (QDEPTH)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({r_tag_pc, io_fetch.mem_rdata}),
    .i_pop   (w_pop),
    .i_flush (io_fetch.flush),
    .o_head  (w_head),
    .o_count (w_q_count)
  );

  assign io_fetch.instr_valid = w_q_nonempty;
  assign io_fetch.instr       = w_q_nonempty ? w_head[INSTR_W-1:0] : INSTR_W'(NOP);
  assign io_fetch.instr_pc    = w_q_nonempty ? w_head[ADDR_W+INSTR_W-1:INSTR_W] : '0;
  assign io_fetch.fetch_count = r_fetch_count;

endmodule : instruction_fetch
`default_nettype wire
